// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared encodings for the instruction sequencer: FSM states,
//                branch-select codes, memory-data select and HALT opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [1:0] BS_INC  = 2'b00;
    localparam logic [1:0] BS_COND = 2'b01;
    localparam logic [1:0] BS_JMP  = 2'b10;
    localparam logic [1:0] BS_REL  = 2'b11;

    localparam logic [1:0] MD_LOAD = 2'b01;

    localparam logic [4:0] HALT_OPCODE = 5'b11111;

endpackage
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_unit
//  Description : Combinational next-PC selection: increment, conditional
//                relative branch, register jump, unconditional relative.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_unit
    import ctrl_pkg::*;
#(
    parameter int PC_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [5:0]          offset,
    input  logic [1:0]          bs,
    input  logic                ps,
    input  logic                zero,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [PC_WIDTH-1:0] pc_next
);

    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_pc_rel;

    // Offset is a signed 6-bit displacement relative to the current pc
    assign w_pc_inc = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    assign w_pc_rel = pc + {{(PC_WIDTH-6){offset[5]}}, offset};

    // Select the next pc from the branch-select code
    always_comb begin
        pc_next = w_pc_inc;
        case (bs)
            BS_INC:  pc_next = w_pc_inc;
            BS_COND: pc_next = (zero == ps) ? w_pc_rel : w_pc_inc;
            BS_JMP:  pc_next = jump_target;
            BS_REL:  pc_next = w_pc_rel;
            default: pc_next = w_pc_inc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Multi-cycle FETCH/DECODE/EXEC/MEM/HALT control sequencer.
//                Holds the IR, qualifies register/memory write strobes and
//                advances the PC and retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import ctrl_pkg::*;
#(
    parameter int INS_WIDTH = 17,
    parameter int PC_WIDTH  = 8,
    parameter int SH_WIDTH  = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic [INS_WIDTH-1:0] imem_rdata,
    input  logic                 imem_valid,
    output logic [INS_WIDTH-1:0] ir,
    input  logic                 dec_RW,
    input  logic                 dec_MW,
    input  logic [SH_WIDTH-1:0]  dec_MD,
    input  logic [SH_WIDTH-1:0]  dec_BS,
    input  logic                 dec_PS,
    input  logic                 zero,
    input  logic [PC_WIDTH-1:0]  jump_target,
    output logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic                 rw_en,
    output logic                 mw_en,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instr_count
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [INS_WIDTH-1:0]   r_ir;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_halted;

    logic [PC_WIDTH-1:0]    w_pc_next;
    logic                   w_is_halt;
    logic                   w_is_mem;
    logic                   w_load_ir;
    logic                   w_pc_upd;
    logic                   w_retire;
    logic                   w_set_halt;

    assign w_is_halt = (r_ir[INS_WIDTH-1 -: 5] == HALT_OPCODE);
    assign w_is_mem  = dec_MW || (dec_MD == MD_LOAD);

    pc_next_unit #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next (
        .pc          (r_pc),
        .offset      (r_ir[5:0]),
        .bs          (dec_BS),
        .ps          (dec_PS),
        .zero        (zero),
        .jump_target (jump_target),
        .pc_next     (w_pc_next)
    );

    // Next-state and strobe decode; all strobes are combinational
    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        rw_en        = 1'b0;
        mw_en        = 1'b0;
        w_load_ir    = 1'b0;
        w_pc_upd     = 1'b0;
        w_retire     = 1'b0;
        w_set_halt   = 1'b0;
        case (r_state)
            FETCH: begin
                imem_req = run;
                if (run && imem_valid) begin
                    w_load_ir    = 1'b1;
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                w_next_state = EXEC;
            end
            EXEC: begin
                if (w_is_halt) begin
                    w_set_halt   = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = HALT;
                end else if (w_is_mem) begin
                    w_next_state = MEM;
                end else begin
                    rw_en        = dec_RW;
                    w_pc_upd     = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = FETCH;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                mw_en    = dec_MW;
                if (dmem_ready) begin
                    rw_en        = dec_RW;
                    w_pc_upd     = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = FETCH;
                end
            end
            HALT: begin
                w_next_state = HALT;
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    // State, IR, PC, counter and halt flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FETCH;
            r_pc     <= '0;
            r_ir     <= '0;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load_ir)  r_ir     <= imem_rdata;
            if (w_pc_upd)   r_pc     <= w_pc_next;
            if (w_retire)   r_cnt    <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (w_set_halt) r_halted <= 1'b1;
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign ir          = r_ir;
    assign halted      = r_halted;
    assign instr_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Directed self-checking bench for instr_sequencer. The bench
//                plays the role of insdec by driving the dec_* inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [16:0] imem_rdata;
    logic        imem_valid;
    logic [16:0] ir;
    logic        dec_RW;
    logic        dec_MW;
    logic [1:0]  dec_MD;
    logic [1:0]  dec_BS;
    logic        dec_PS;
    logic        zero;
    logic [7:0]  jump_target;
    logic        dmem_req;
    logic        dmem_ready;
    logic        rw_en;
    logic        mw_en;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] instr_count;

    int total;
    int bad;

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .ir          (ir),
        .dec_RW      (dec_RW),
        .dec_MW      (dec_MW),
        .dec_MD      (dec_MD),
        .dec_BS      (dec_BS),
        .dec_PS      (dec_PS),
        .zero        (zero),
        .jump_target (jump_target),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .rw_en       (rw_en),
        .mw_en       (mw_en),
        .pc          (pc),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] mk(input logic [4:0] op, input logic [5:0] off);
        return {op, 6'd0, off};
    endfunction

    // Set decoder outputs for the instruction about to be fetched
    task automatic set_dec(input logic rw, input logic mw, input logic [1:0] md,
                           input logic [1:0] bs, input logic ps);
        dec_RW = rw; dec_MW = mw; dec_MD = md; dec_BS = bs; dec_PS = ps;
    endtask

    // From FETCH: present an instruction, check the request, end in DECODE
    task automatic fetch_issue(input string tag, input logic [16:0] instr, input logic [7:0] exp_pc);
        run = 1'b1; imem_valid = 1'b1; imem_rdata = instr;
        #1;
        chk({tag, "_imem_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'(exp_pc));
        tick();
        run = 1'b0; imem_valid = 1'b0;
    endtask

    // Run a non-memory instruction through DECODE and EXEC back to FETCH
    task automatic alu_instr(input string tag, input logic [16:0] instr, input logic [7:0] exp_pc,
                             input logic [7:0] exp_next, input logic [15:0] exp_cnt);
        fetch_issue(tag, instr, exp_pc);
        tick();
        tick();
        chk({tag, "_pc"}, 32'(pc), 32'(exp_next));
        chk({tag, "_cnt"}, 32'(instr_count), 32'(exp_cnt));
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; run = 1'b0; imem_rdata = '0; imem_valid = 1'b0;
        dec_RW = 1'b0; dec_MW = 1'b0; dec_MD = 2'b00; dec_BS = 2'b00; dec_PS = 1'b0;
        zero = 1'b0; jump_target = '0; dmem_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_cnt", 32'(instr_count), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_strobes", {28'd0, imem_req, dmem_req, rw_en, mw_en}, 32'h0);

        // ALU instruction: RW pulses only in cycle 3, refetch in cycle 4
        set_dec(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        fetch_issue("alu", mk(5'b00001, 6'd0), 8'h00);
        chk("alu_c2_ir", 32'(ir), 32'(mk(5'b00001, 6'd0)));
        chk("alu_c2_rw", 32'(rw_en), 32'd0);
        chk("alu_c2_req", 32'(imem_req), 32'd0);
        tick();
        chk("alu_c3_rw", 32'(rw_en), 32'd1);
        chk("alu_c3_pc", 32'(pc), 32'h00);
        run = 1'b1; imem_valid = 1'b0;
        tick();
        chk("alu_c4_rw", 32'(rw_en), 32'd0);
        chk("alu_c4_req", 32'(imem_req), 32'd1);
        chk("alu_c4_pc", 32'(pc), 32'h01);
        chk("alu_c4_cnt", 32'(instr_count), 32'd1);
        run = 1'b0;
        #1;
        chk("run0_req", 32'(imem_req), 32'd0);

        // Register jump to 0x10, conditional branch taken (zero==PS) to 0x0E
        set_dec(1'b0, 1'b0, 2'b00, 2'b10, 1'b0); jump_target = 8'h10;
        alu_instr("jmp1", mk(5'b00010, 6'd0), 8'h01, 8'h10, 16'd2);
        set_dec(1'b0, 1'b0, 2'b00, 2'b01, 1'b1); zero = 1'b1;
        alu_instr("bz_taken", mk(5'b00011, 6'b111110), 8'h10, 8'h0E, 16'd3);
        // Back to 0x10, branch not taken with zero=0
        set_dec(1'b0, 1'b0, 2'b00, 2'b10, 1'b0);
        alu_instr("jmp2", mk(5'b00010, 6'd0), 8'h0E, 8'h10, 16'd4);
        set_dec(1'b0, 1'b0, 2'b00, 2'b01, 1'b1); zero = 1'b0;
        alu_instr("bz_ntaken", mk(5'b00011, 6'b111110), 8'h10, 8'h11, 16'd5);
        // Unconditional relative +3
        set_dec(1'b0, 1'b0, 2'b00, 2'b11, 1'b0);
        alu_instr("rel", mk(5'b00100, 6'b000011), 8'h11, 8'h14, 16'd6);

        // Store with ready on the third MEM cycle
        set_dec(1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        fetch_issue("st", mk(5'b00101, 6'd0), 8'h14);
        tick();
        chk("st_exec_dreq", 32'(dmem_req), 32'd0);
        chk("st_exec_mw", 32'(mw_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            dmem_ready = (i == 2);
            #1;
            chk("st_mem_dreq", 32'(dmem_req), 32'd1);
            chk("st_mem_mw", 32'(mw_en), 32'd1);
            chk("st_mem_rw", 32'(rw_en), 32'd0);
            chk("st_mem_pc", 32'(pc), 32'h14);
        end
        tick();
        dmem_ready = 1'b0;
        #1;
        chk("st_done_dreq", 32'(dmem_req), 32'd0);
        chk("st_done_mw", 32'(mw_en), 32'd0);
        chk("st_done_pc", 32'(pc), 32'h15);
        chk("st_done_cnt", 32'(instr_count), 32'd7);

        // Load: RW pulses only in the dmem_ready cycle
        set_dec(1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
        fetch_issue("ld", mk(5'b00110, 6'd0), 8'h15);
        tick();
        chk("ld_exec_rw", 32'(rw_en), 32'd0);
        tick();
        chk("ld_wait_rw", 32'(rw_en), 32'd0);
        chk("ld_wait_mw", 32'(mw_en), 32'd0);
        chk("ld_wait_dreq", 32'(dmem_req), 32'd1);
        tick();
        dmem_ready = 1'b1;
        #1;
        chk("ld_rdy_rw", 32'(rw_en), 32'd1);
        tick();
        dmem_ready = 1'b0;
        #1;
        chk("ld_done_rw", 32'(rw_en), 32'd0);
        chk("ld_done_pc", 32'(pc), 32'h16);
        chk("ld_done_cnt", 32'(instr_count), 32'd8);

        // PC wrap: jump to 0xFF, then increment to 0x00
        set_dec(1'b0, 1'b0, 2'b00, 2'b10, 1'b0); jump_target = 8'hFF;
        alu_instr("jmpff", mk(5'b00010, 6'd0), 8'h16, 8'hFF, 16'd9);
        set_dec(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        alu_instr("wrap", mk(5'b00001, 6'd0), 8'hFF, 8'h00, 16'd10);

        // HALT at 0x05
        set_dec(1'b0, 1'b0, 2'b00, 2'b10, 1'b0); jump_target = 8'h05;
        alu_instr("jmp5", mk(5'b00010, 6'd0), 8'h00, 8'h05, 16'd11);
        set_dec(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        fetch_issue("halt", mk(5'b11111, 6'd0), 8'h05);
        tick();
        chk("halt_exec_rw", 32'(rw_en), 32'd0);
        tick();
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'h05);
        chk("halt_cnt", 32'(instr_count), 32'd12);
        run = 1'b1; imem_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("halt_req", 32'(imem_req), 32'd0);
            tick();
        end
        chk("halt_pc_hold", 32'(pc), 32'h05);
        run = 1'b0; imem_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("halt_rst_pc", 32'(pc), 32'h00);
        chk("halt_rst_flag", 32'(halted), 32'd0);
        chk("halt_rst_cnt", 32'(instr_count), 32'd0);

        // Reset while waiting in MEM
        set_dec(1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        fetch_issue("mrst", mk(5'b00101, 6'd0), 8'h00);
        tick();
        tick();
        chk("mrst_in_mem", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_dreq", 32'(dmem_req), 32'd0);
        chk("mrst_mw", 32'(mw_en), 32'd0);
        chk("mrst_pc", 32'(pc), 32'h00);
        chk("mrst_cnt", 32'(instr_count), 32'd0);
        chk("mrst_ir", 32'(ir), 32'h0);
        chk("mrst_req", 32'(imem_req), 32'd0);
        tick();
        tick();
        chk("mrst_req_hold", 32'(imem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control sequencer for the 17-bit processor datapath. It fetches instructions from instruction memory and holds them in the IR that feeds insdec. It then gates the decoder's RW/MW strobes into single-cycle or handshake-qualified enables and computes the next PC from BS/PS and the zero flag. It sits between the instruction/data memories, insdec and the register file/PC.

Parameters:
INS_WIDTH, 17, instruction width; opcode = IR[16:12], DA = IR[11:9], AA = IR[8:6], BA = IR[5:3], IR[2:0] spare.
PC_WIDTH, 8, program counter and memory address width.
SH_WIDTH, 2, width of BS and MD fields.
CNT_WIDTH, 16, retired-instruction counter width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
run  in  1  permits a new fetch when high.
imem_req  out  1  instruction fetch request.
imem_addr  out  PC_WIDTH  fetch address, equal to pc.
imem_rdata  in  INS_WIDTH  fetched instruction.
imem_valid  in  1  imem_rdata valid this cycle.
ir  out  INS_WIDTH  instruction register, drives insdec.
dec_RW  in  1  register write request from insdec.
dec_MW  in  1  memory write request from insdec.
dec_MD  in  SH_WIDTH  insdec MD; 2'b01 = load from data memory.
dec_BS  in  SH_WIDTH  branch select from insdec.
dec_PS  in  1  branch polarity from insdec.
zero  in  1  ALU zero flag, valid in EXEC.
jump_target  in  PC_WIDTH  register-sourced jump address (bus A).
dmem_req  out  1  data-memory access request.
dmem_ready  in  1  data-memory access complete.
rw_en  out  1  register-file write enable.
mw_en  out  1  data-memory write enable.
pc  out  PC_WIDTH  program counter.
halted  out  1  HALT opcode executed.
instr_count  out  CNT_WIDTH  retired instructions, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset is synchronous: on a clk edge with rst=1, state=FETCH, pc=0, ir=0, instr_count=0, halted=0. All strobes (imem_req, dmem_req, rw_en, mw_en) are 0.
- rst overrides every state, including mid-MEM and HALT. Outstanding memory responses are abandoned; the memories share rst and drop valid/ready.
- All strobes are combinational from state and inputs. pc, ir, instr_count, halted and state are registered.
- FETCH:
  - imem_req = run.
  - If run && imem_valid: ir <= imem_rdata, go to DECODE. imem_valid may arrive in the same cycle as the request.
  - Otherwise stay in FETCH; ir is held.
  - run=0 blocks only new fetches. An instruction already past FETCH always completes.
- DECODE: one cycle for insdec outputs to settle. No strobes. Always go to EXEC.
- EXEC:
  - If ir[16:12] == HALT_OPCODE (5'b11111): go to HALT, set halted=1. pc is not updated; instr_count increments.
  - Else if dec_MW=1 or dec_MD=2'b01: go to MEM. No strobes.
  - Else: rw_en = dec_RW for exactly this cycle, pc <= pc_next, instr_count += 1, go to FETCH.
- MEM:
  - dmem_req=1 and mw_en=dec_MW for every cycle in MEM.
  - On dmem_ready=1: rw_en = dec_RW (load data is muxed by MD), pc <= pc_next, instr_count += 1, go to FETCH.
  - No timeout; MEM waits indefinitely.
- HALT: no strobes. Stays in HALT until rst; run is ignored.
- Next PC, all arithmetic modulo 2^PC_WIDTH:
  - BS=00: pc+1.
  - BS=01: if (zero == dec_PS) then pc + sext(ir[5:0]), else pc+1.
  - BS=10: jump_target.
  - BS=11: pc + sext(ir[5:0]) unconditionally.
- Wrap-around: pc=8'hFF with BS=00 gives 8'h00. instr_count=16'hFFFF retiring gives 16'h0000.
- Minimum latency: 3 cycles for ALU/branch instructions, 4 cycles for memory instructions (imem_valid and dmem_ready both immediate).

Decomposition:
- Shared package ctrl_pkg holds:
  - state encoding FETCH=3'd0, DECODE=3'd1, EXEC=3'd2, MEM=3'd3, HALT=3'd4;
  - BS_INC, BS_COND, BS_JMP, BS_REL;
  - MD_LOAD=2'b01;
  - HALT_OPCODE=5'b11111.
- One combinational sub-module, pc_next_unit (pc, ir[5:0], BS, PS, zero, jump_target -> pc_next), unit-testable on its own.

Test Plan:
- Reset, run=1, imem_valid=1 every cycle, ALU instruction (BS=00, RW=1, MW=0, MD=00): rw_en high only in cycle 3; pc 0->1; instr_count=1; next imem_req in cycle 4.
- Conditional branch at pc=8'h10, ir[5:0]=6'b111110, BS=01, PS=1: with zero=1, pc->8'h0E; rerun with zero=0, pc->8'h11.
- Store (MW=1) with dmem_ready delayed 3 cycles: dmem_req and mw_en high for 3 cycles, drop the cycle after ready; pc increments once; rw_en stays 0.
- Load (MD=01, RW=1): rw_en pulses only in the dmem_ready cycle; instr_count increments once.
- HALT opcode fetched at pc=8'h05: halted=1, pc stays 8'h05, imem_req stays 0 for 20 cycles with run=1; rst then returns pc=0, halted=0.
- rst asserted in MEM with dmem_ready low: next cycle state=FETCH, dmem_req=0, pc=0, instr_count=0; run=0 afterwards keeps imem_req=0.
